// File: rtl/pulse_multiplier_iterative_pulse_latch.sv
// Sticky flag: set by a one-cycle pulse, held until a synchronous clear.
// Clear has priority over a simultaneous set pulse.
module Pulse_Latch #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clock,
  input  logic clear,
  input  logic pulse_in,
  output logic level_out
);

  logic level_q;
  logic level_d;

  always_comb begin
    level_d = level_q;
    if (pulse_in) begin
      level_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      level_q <= RESET_VALUE;
    end else begin
      level_q <= level_d;
    end
  end

  assign level_out = level_q;

endmodule

// File: rtl/pulse_multiplier_iterative.sv
// Variable-latency unsigned shift-add multiplier with one-cycle pulse handshakes.
// The multiply ends as soon as the remaining multiplier bits are all zero.
module pulse_multiplier_iterative #(
  parameter int WORD_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  clear_n,
  input  logic                  pulse_in,
  input  logic [WORD_WIDTH-1:0] data_in,
  output logic                  pulse_out,
  output logic [WORD_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  overlap_error
);

  localparam int HALF = WORD_WIDTH / 2;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  logic                  state_q, state_d;
  logic [WORD_WIDTH-1:0] a_q, a_d;
  logic [HALF-1:0]       b_q, b_d;
  logic [WORD_WIDTH-1:0] acc_q, acc_d;
  logic [WORD_WIDTH-1:0] data_q, data_d;
  logic                  pulse_q, pulse_d;
  logic [WORD_WIDTH-1:0] acc_next;
  logic [HALF-1:0]       b_shifted;

  assign acc_next  = acc_q + (b_q[0] ? a_q : '0);
  assign b_shifted = b_q >> 1;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    data_d  = data_q;
    pulse_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pulse_in) begin
          a_d     = {{HALF{1'b0}}, data_in[WORD_WIDTH-1:HALF]};
          b_d     = data_in[HALF-1:0];
          acc_d   = '0;
          state_d = ST_RUN;
        end
      end
      default: begin
        a_d   = a_q << 1;
        b_d   = b_shifted;
        acc_d = acc_next;
        // No set bits left above bit 0: this cycle's sum is the product.
        if (b_shifted == '0) begin
          data_d  = acc_next;
          pulse_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      pulse_q <= pulse_d;
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign pulse_out = pulse_q;
  assign data_out  = data_q;

  Pulse_Latch #(
    .RESET_VALUE(1'b0)
  ) u_overlap_latch (
    .clock    (clock),
    .clear    (~clear_n),
    .pulse_in (pulse_in & busy),
    .level_out(overlap_error)
  );

endmodule

// File: tb/tb_pulse_multiplier_iterative.sv
// Directed and randomized checks of the iterative pulse multiplier (WORD_WIDTH=16).
module tb_pulse_multiplier_iterative;

  localparam int W = 16;
  localparam int H = W / 2;

  logic         clock = 1'b0;
  logic         clear_n;
  logic         pulse_in;
  logic [W-1:0] data_in;
  logic         pulse_out;
  logic [W-1:0] data_out;
  logic         busy;
  logic         overlap_error;

  int vectors = 0;
  int errors  = 0;
  logic [W-1:0] last_prod;

  pulse_multiplier_iterative #(.WORD_WIDTH(W)) dut (
    .clock        (clock),
    .clear_n      (clear_n),
    .pulse_in     (pulse_in),
    .data_in      (data_in),
    .pulse_out    (pulse_out),
    .data_out     (data_out),
    .busy         (busy),
    .overlap_error(overlap_error)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int exp_latency(input logic [H-1:0] m);
    int k;
    k = 1;
    for (int i = 0; i < H; i++) begin
      if (m[i]) k = i + 1;
    end
    return k + 1;
  endfunction

  // Issue one operation in the current cycle and wait for its pulse_out.
  // Returns in the pulse_out cycle so the caller may start the next one there.
  task automatic run_op(input string tag, input logic [W-1:0] din,
                        input logic [W-1:0] exp_prod, input int exp_lat);
    int   n;
    logic hold_ok;
    data_in  = din;
    pulse_in = 1'b1;
    tick();
    pulse_in = 1'b0;
    n        = 1;
    hold_ok  = 1'b1;
    while (!pulse_out && n < 40) begin
      if (data_out !== last_prod) hold_ok = 1'b0;
      tick();
      n++;
    end
    check({tag, "_latency"}, W'(n), W'(exp_lat));
    check({tag, "_product"}, data_out, exp_prod);
    check({tag, "_hold"}, {{(W-1){1'b0}}, hold_ok}, 16'h0001);
    last_prod = exp_prod;
  endtask

  initial begin
    logic       soak_hold_ok;
    logic [H-1:0] ma, mb;
    clear_n   = 1'b0;
    pulse_in  = 1'b0;
    data_in   = '0;
    last_prod = '0;

    repeat (3) tick();
    clear_n = 1'b1;
    tick();
    check("rst_pulse_out", {15'd0, pulse_out}, 16'h0000);
    check("rst_data_out", data_out, 16'h0000);
    check("rst_busy", {15'd0, busy}, 16'h0000);
    check("rst_overlap", {15'd0, overlap_error}, 16'h0000);

    // 13 * 11, multiplier bit-length 4: busy t+1..t+4, pulse at t+5.
    data_in  = 16'h0D0B;
    pulse_in = 1'b1;
    tick();
    pulse_in = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("d0b_busy_t%0d", c), {15'd0, busy}, 16'h0001);
      check($sformatf("d0b_nopulse_t%0d", c), {15'd0, pulse_out}, 16'h0000);
      tick();
    end
    check("d0b_pulse_t5", {15'd0, pulse_out}, 16'h0001);
    check("d0b_data_t5", data_out, 16'h008F);
    check("d0b_idle_t5", {15'd0, busy}, 16'h0000);
    tick();
    check("d0b_pulse_t6", {15'd0, pulse_out}, 16'h0000);
    check("d0b_data_t6", data_out, 16'h008F);
    last_prod = 16'h008F;

    tick();
    run_op("mul0", 16'hFF00, 16'h0000, 2);
    tick();
    run_op("ones", 16'hFFFF, 16'hFE01, 9);

    tick();
    run_op("b2b_a", 16'h0302, 16'h0006, 3);
    run_op("b2b_b", 16'h0505, 16'h0019, 4);
    check("b2b_overlap", {15'd0, overlap_error}, 16'h0000);

    // Extra pulse_in at t+2 must be ignored and flagged sticky.
    tick();
    data_in  = 16'h0A0F;
    pulse_in = 1'b1;
    tick();
    pulse_in = 1'b0;
    tick();
    data_in  = 16'h0101;
    pulse_in = 1'b1;
    check("ovl_before", {15'd0, overlap_error}, 16'h0000);
    tick();
    pulse_in = 1'b0;
    check("ovl_set_t3", {15'd0, overlap_error}, 16'h0001);
    check("ovl_busy_t3", {15'd0, busy}, 16'h0001);
    tick();
    check("ovl_nopulse_t4", {15'd0, pulse_out}, 16'h0000);
    tick();
    check("ovl_pulse_t5", {15'd0, pulse_out}, 16'h0001);
    check("ovl_data_t5", data_out, 16'h0096);
    tick();
    check("ovl_sticky", {15'd0, overlap_error}, 16'h0001);
    check("ovl_no_second", {15'd0, pulse_out | busy}, 16'h0000);

    // Reset in the middle of a multiply.
    data_in  = 16'h1234;
    pulse_in = 1'b1;
    tick();
    pulse_in = 1'b0;
    tick();
    clear_n = 1'b0;
    tick();
    clear_n = 1'b1;
    check("mrst_busy", {15'd0, busy}, 16'h0000);
    check("mrst_data", data_out, 16'h0000);
    check("mrst_overlap", {15'd0, overlap_error}, 16'h0000);
    soak_hold_ok = 1'b1;
    repeat (10) begin
      if (pulse_out !== 1'b0 || data_out !== 16'h0000) soak_hold_ok = 1'b0;
      tick();
    end
    check("mrst_no_pulse", {15'd0, soak_hold_ok}, 16'h0001);
    last_prod = '0;

    for (int i = 0; i < 1000; i++) begin
      ma = H'($urandom_range(0, 255));
      case ($urandom_range(0, 5))
        0:       mb = '0;
        1:       mb = 8'd1;
        2:       mb = 8'hFF;
        default: mb = H'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 1) == 1) tick();
      run_op($sformatf("soak%0d", i), {ma, mb}, W'(ma) * W'(mb), exp_latency(mb));
    end
    check("soak_overlap", {15'd0, overlap_error}, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
